// File: rtl/fetch_queue_unit.sv
// fetch_queue_unit
// Instruction fetch front end with a small in-order instruction buffer.
// The unit issues at most one memory request at a time. Each response is
// pushed into a DEPTH-entry FIFO, and the head of the FIFO is shown to decode.
// A redirect (pcsrc) flushes the FIFO and restarts fetch at the branch target.
// If a redirect arrives while a request is still in flight, the stale
// response is discarded when it comes back (DROP state).
//
// Ports
//   clk, rst_n      : rising-edge clock, asynchronous active-low reset
//   pcsrc           : redirect request; wins over stall, pop, push and request
//   branch_target   : redirect address (low two bits forced to zero)
//   stall           : decode cannot accept the head entry this cycle
//   imem_req        : memory request valid (combinational)
//   imem_addr       : memory request address (current fetch pc)
//   imem_gnt        : memory accepted the request this cycle
//   imem_rvalid     : memory response valid
//   imem_rdata      : memory response instruction
//   if_valid        : buffer holds at least one entry
//   instruction     : head instruction (0 when the buffer is empty)
//   pc_out          : head instruction address (0 when the buffer is empty)
//   adderOutput     : pc_out + 4, wrapping at ADDR_W bits
module fetch_queue_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pcsrc,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              if_valid,
  output logic [DATA_W-1:0] instruction,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] adderOutput
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_INC     = ADDR_W'(32'd4);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(32'd3));
  localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1'b1);
  localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1'b1);

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DROP  = 2'd2
  } state_t;

  state_t              state_r;
  state_t              state_next_s;
  logic [ADDR_W-1:0]   fetch_pc_r;
  logic [ADDR_W-1:0]   req_pc_r;
  logic [PTR_W-1:0]    rd_ptr_r;
  logic [PTR_W-1:0]    wr_ptr_r;
  logic [CNT_W-1:0]    count_r;
  logic [ADDR_W-1:0]   pc_mem_r   [DEPTH];
  logic [DATA_W-1:0]   data_mem_r [DEPTH];

  logic                req_s;
  logic                accept_s;
  logic                push_s;
  logic                pop_s;
  logic                not_empty_s;
  logic [ADDR_W-1:0]   target_s;

  assign target_s    = branch_target & ALIGN_MASK;
  assign not_empty_s = (count_r != {CNT_W{1'b0}});
  assign accept_s    = req_s & imem_gnt;
  // A response is only kept when it answers a live request and no redirect
  // is flushing the buffer in the same cycle.
  assign push_s      = (state_r == ST_WAIT) & imem_rvalid & ~pcsrc;
  assign pop_s       = not_empty_s & ~stall & ~pcsrc;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_FETCH;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_FETCH: begin
        if (accept_s) begin
          state_next_s = ST_WAIT;
        end else begin
          state_next_s = ST_FETCH;
        end
      end
      ST_WAIT: begin
        if (imem_rvalid) begin
          state_next_s = ST_FETCH;
        end else if (pcsrc) begin
          state_next_s = ST_DROP;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_DROP: begin
        // Further redirects only move fetch_pc; the stale reply must still drain.
        if (imem_rvalid) begin
          state_next_s = ST_FETCH;
        end else begin
          state_next_s = ST_DROP;
        end
      end
      default: begin
        state_next_s = ST_FETCH;
      end
    endcase
  end

  // FSM outputs: request only from FETCH with room in the buffer
  always_comb begin
    req_s = 1'b0;
    case (state_r)
      ST_FETCH: begin
        if ((count_r < DEPTH_C) && !pcsrc) begin
          req_s = 1'b1;
        end else begin
          req_s = 1'b0;
        end
      end
      default: begin
        req_s = 1'b0;
      end
    endcase
  end

  assign imem_req  = req_s;
  assign imem_addr = fetch_pc_r;

  // Fetch and request address tracking
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_r <= RESET_PC;
      req_pc_r   <= RESET_PC;
    end else if (pcsrc) begin
      fetch_pc_r <= target_s;
    end else if (accept_s) begin
      req_pc_r   <= fetch_pc_r;
      fetch_pc_r <= fetch_pc_r + PC_INC;
    end
  end

  // Buffer pointers and occupancy; a redirect empties the buffer
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (pcsrc) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Buffer storage; contents are only visible while count is non-zero
  always_ff @(posedge clk) begin
    if (push_s) begin
      pc_mem_r[wr_ptr_r]   <= req_pc_r;
      data_mem_r[wr_ptr_r] <= imem_rdata;
    end
  end

  // Head-of-buffer outputs, forced to zero when empty
  always_comb begin
    if_valid    = not_empty_s;
    instruction = {DATA_W{1'b0}};
    pc_out      = {ADDR_W{1'b0}};
    if (not_empty_s) begin
      instruction = data_mem_r[rd_ptr_r];
      pc_out      = pc_mem_r[rd_ptr_r];
    end else begin
      instruction = {DATA_W{1'b0}};
      pc_out      = {ADDR_W{1'b0}};
    end
  end

  assign adderOutput = pc_out + PC_INC;

endmodule

// File: doc/fetch_queue_unit.md
FETCH_QUEUE_UNIT -- requirements
Module: fetch_queue_unit

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W  32  PC / memory address width.
  DATA_W  32  instruction width.
  DEPTH  2  instruction buffer entries (power of two, >=2).
  RESET_PC  0  first fetch address after reset.
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning. One clock; reset is asynchronous and active-low.
  clk  in  1  rising-edge clock.
  rst_n  in  1  asynchronous active-low reset.
  pcsrc  in  1  redirect request (branch taken).
  branch_target  in  ADDR_W  redirect address; bits [1:0] treated as 0.
  stall  in  1  decode cannot accept this cycle.
  imem_req  out  1  memory request valid.
  imem_addr  out  ADDR_W  request address.
  imem_gnt  in  1  request accepted this cycle.
  imem_rvalid  in  1  response data valid.
  imem_rdata  in  DATA_W  response instruction.
  if_valid  out  1  instruction/pc outputs valid.
  instruction  out  DATA_W  head-of-buffer instruction.
  pc_out  out  ADDR_W  address of head instruction.
  adderOutput  out  ADDR_W  pc_out + 4, modulo 2^ADDR_W.

Function
REQ-003 FSM states SHALL be FETCH, WAIT, DROP; at most one outstanding memory request.
REQ-004 imem_req SHALL be combinational: state==FETCH && count<DEPTH && !pcsrc; imem_addr = fetch_pc.
REQ-005 Request accept (imem_req && imem_gnt): req_pc <= fetch_pc, fetch_pc <= fetch_pc+4 (wraps), FETCH->WAIT.
REQ-006 WAIT with imem_rvalid && !pcsrc: push {req_pc, imem_rdata} into buffer, WAIT->FETCH.
REQ-007 imem_rvalid in FETCH SHALL be ignored.
REQ-008 if_valid = (count != 0); instruction/pc_out show head entry; outputs SHALL be 0 when count==0.
REQ-009 Pop SHALL occur when if_valid && !stall && !pcsrc; simultaneous push and pop leaves count unchanged.
REQ-010 Buffer SHALL never overflow: request issued only when count<DEPTH, so every response has space.
REQ-011 Redirect (pcsrc=1) SHALL have priority over stall, pop, push and request: buffer flushed (count=0) on the next edge, fetch_pc <= {branch_target[ADDR_W-1:2],2'b00}.
REQ-012 Redirect in WAIT without imem_rvalid: WAIT->DROP; with imem_rvalid same cycle: data discarded, WAIT->FETCH.
REQ-013 DROP: imem_rvalid discarded, DROP->FETCH; a further pcsrc in DROP updates fetch_pc and keeps DROP unless imem_rvalid is coincident (then FETCH).
REQ-014 Redirect in FETCH: no request that cycle; next cycle requests the target.
REQ-015 adderOutput SHALL be combinational pc_out+4, truncated to ADDR_W (0xFFFFFFFC -> 0x00000000).
REQ-016 Response latency is unbounded; gnt may stay low indefinitely with imem_req held and imem_addr stable.
REQ-017 Best-case throughput: one instruction every 2 cycles with gnt=1 and 1-cycle response.

Reset
REQ-018 rst_n=0 SHALL immediately force: state FETCH, fetch_pc=RESET_PC, count=0, if_valid=0, instruction=0, pc_out=0, adderOutput=4.
REQ-019 Reset mid-WAIT/DROP SHALL abandon the outstanding request; responses arriving before the first post-reset request are ignored (REQ-007).
REQ-020 First imem_req SHALL assert in the first cycle after rst_n deasserts (if pcsrc=0), with imem_addr=RESET_PC.

Verification
REQ-021 Reset release, gnt=1, 1-cycle rvalid with rdata=0x1111_0000+addr, stall=0 -> pc_out 0,4,8,... each with matching instruction, adderOutput=pc_out+4.
REQ-022 stall=1 held for 10 cycles -> buffer fills to DEPTH, imem_req drops, head stays pc_out=0x0; stall release -> in-order drain, no loss or duplicate.
REQ-023 pcsrc=1, branch_target=0x0000_0103 while WAIT (rvalid 3 cycles later) -> old response discarded, if_valid=0 until fetch of 0x0000_0100 returns; next pc 0x104.
REQ-024 pcsrc and rvalid same cycle in WAIT, also pcsrc with stall=1 -> data dropped, buffer flushed, redirect taken.
REQ-025 Jump to 0xFFFF_FFFC -> pc_out=0xFFFF_FFFC, adderOutput=0x0, next fetch address 0x0.
REQ-026 rst_n pulsed low mid-WAIT, late rvalid after release ignored -> first output pc_out=RESET_PC.
